// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared definitions for the mux3 round-robin arbiter: FSM states, mux
// select encodings, statistics field width and a saturating increment helper.
package mux3_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;

    localparam int STAT_W = 16;

    // Increment a statistics field, sticking at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == {STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + STAT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way rotating-priority picker. The requester just
// after i_last_owner has highest priority; i_last_owner itself is scanned last.
module rr_pick3
    import mux3_rr_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_last_owner,
    output logic [2:0] o_pick_oh,
    output logic [1:0] o_pick_idx,
    output logic       o_any
);

    // Scan the requests in rotated order and produce index, one-hot and any.
    always_comb begin
        o_any      = |i_req;
        o_pick_idx = SEL_REQ0;
        o_pick_oh  = 3'b000;

        case (i_last_owner)
            SEL_REQ0: begin
                if (i_req[1])      o_pick_idx = SEL_REQ1;
                else if (i_req[2]) o_pick_idx = SEL_REQ2;
                else               o_pick_idx = SEL_REQ0;
            end
            SEL_REQ1: begin
                if (i_req[2])      o_pick_idx = SEL_REQ2;
                else if (i_req[0]) o_pick_idx = SEL_REQ0;
                else if (i_req[1]) o_pick_idx = SEL_REQ1;
                else               o_pick_idx = SEL_REQ0;
            end
            default: begin
                if (i_req[0])      o_pick_idx = SEL_REQ0;
                else if (i_req[1]) o_pick_idx = SEL_REQ1;
                else if (i_req[2]) o_pick_idx = SEL_REQ2;
                else               o_pick_idx = SEL_REQ0;
            end
        endcase

        if (o_any) begin
            case (o_pick_idx)
                SEL_REQ1: o_pick_oh = 3'b010;
                SEL_REQ2: o_pick_oh = 3'b100;
                default:  o_pick_oh = 3'b001;
            endcase
        end else begin
            o_pick_oh = 3'b000;
        end
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin owner of a 3-input 8-bit select mux.
// Grants are held for at most MAX_BURST handshaken beats, then ownership
// rotates at the same edge as the final beat (no idle bubble).
// Optional: define ARB_STATS_EN to add stat_beats, three saturating 16-bit
// per-requester beat counters (field i at bits 16i+15:16i).
module mux3_rr_arbiter
    import mux3_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic                  out_ready,
    output logic [1:0]            sel,
    output logic [2:0]            grant,
    output logic                  out_valid,
    output logic                  beat,
    output logic                  busy
`ifdef ARB_STATS_EN
    ,output logic [3*STAT_W-1:0]  stat_beats
`endif
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [2:0]       r_grant;
    logic [2:0]       w_grant_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       r_last_owner;
    logic [1:0]       w_last_owner_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;
    logic             r_busy;

    logic [2:0]       w_pick_oh;
    logic [1:0]       w_pick_idx;
    logic             w_any;
    logic             w_owner_req;
    logic             w_out_valid;
    logic             w_beat;
    logic             w_release;

    rr_pick3 u_pick (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_pick_oh    (w_pick_oh),
        .o_pick_idx   (w_pick_idx),
        .o_any        (w_any)
    );

    // grant is zero outside GRANT, so the owner's request is simply req masked by grant.
    assign w_owner_req = |(req & r_grant);
    assign w_out_valid = rst_n & (r_state == ST_GRANT) & w_owner_req;
    assign w_beat      = w_out_valid & out_ready;
    assign w_release   = (w_beat & (r_beat_cnt == LAST_BEAT)) | ~w_owner_req;

    // Next-state logic: acquire from IDLE, count beats, release and re-pick in GRANT.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_sel_nxt        = r_sel;
        w_last_owner_nxt = r_last_owner;
        w_beat_cnt_nxt   = r_beat_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt      = ST_GRANT;
                    w_grant_nxt      = w_pick_oh;
                    w_sel_nxt        = w_pick_idx;
                    w_last_owner_nxt = w_pick_idx;
                    w_beat_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_grant_nxt = 3'b000;
                    w_sel_nxt   = SEL_REQ0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // The picker scans the current owner last, so it only
                    // keeps the grant when it is the sole requester.
                    w_beat_cnt_nxt = {CNT_W{1'b0}};
                    if (w_any) begin
                        w_state_nxt      = ST_GRANT;
                        w_grant_nxt      = w_pick_oh;
                        w_sel_nxt        = w_pick_idx;
                        w_last_owner_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 3'b000;
                        w_sel_nxt   = SEL_REQ0;
                    end
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_grant_nxt    = 3'b000;
                w_sel_nxt      = SEL_REQ0;
                w_beat_cnt_nxt = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 3'b000;
            r_sel        <= SEL_REQ0;
            r_last_owner <= SEL_REQ2;
            r_beat_cnt   <= {CNT_W{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_sel        <= w_sel_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_busy       <= (w_state_nxt == ST_GRANT);
        end
    end

    assign sel       = r_sel;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign out_valid = w_out_valid;
    assign beat      = w_beat;

`ifdef ARB_STATS_EN
    logic [3*STAT_W-1:0] r_stat_beats;

    // Per-requester beat counters, attributed to the current owner, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_beats <= {(3*STAT_W){1'b0}};
        end else if (w_beat) begin
            case (r_sel)
                SEL_REQ0: r_stat_beats[STAT_W-1:0]
                              <= sat_inc(r_stat_beats[STAT_W-1:0]);
                SEL_REQ1: r_stat_beats[2*STAT_W-1:STAT_W]
                              <= sat_inc(r_stat_beats[2*STAT_W-1:STAT_W]);
                SEL_REQ2: r_stat_beats[3*STAT_W-1:2*STAT_W]
                              <= sat_inc(r_stat_beats[3*STAT_W-1:2*STAT_W]);
                default:  r_stat_beats <= r_stat_beats;
            endcase
        end else begin
            r_stat_beats <= r_stat_beats;
        end
    end

    assign stat_beats = r_stat_beats;
`endif

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter (MAX_BURST=4): a vector table for
// the round-robin rotation plus directed sequences for single requester,
// early release, stall, reset mid-burst and (with ARB_STATS_EN) statistics.
module tb_mux3_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic        out_ready;
    logic [1:0]  sel;
    logic [2:0]  grant;
    logic        out_valid;
    logic        beat;
    logic        busy;
`ifdef ARB_STATS_EN
    logic [47:0] stat_beats;
`endif

    int checks   = 0;
    int failures = 0;
    int beats    = 0;

    typedef struct {
        logic       rst_n;
        logic [2:0] req;
        logic       rdy;
        logic [2:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       ov;
        logic       bt;
    } vec_t;

    vec_t tbl[17];

    always #5 clk = ~clk;

    mux3_rr_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .sel        (sel),
        .grant      (grant),
        .out_valid  (out_valid),
        .beat       (beat),
        .busy       (busy)
`ifdef ARB_STATS_EN
        ,.stat_beats (stat_beats)
`endif
    );

    function automatic vec_t mk(input logic rn, input logic [2:0] rq, input logic rdy,
                                input logic [2:0] g, input logic [1:0] s,
                                input logic b, input logic v, input logic bt);
        vec_t x;
        x.rst_n = rn; x.req = rq; x.rdy = rdy;
        x.grant = g;  x.sel = s;  x.busy = b; x.ov = v; x.bt = bt;
        return x;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let them settle.
    task automatic drive(input logic rn, input logic [2:0] rq, input logic rdy);
        @(negedge clk);
        rst_n     = rn;
        req       = rq;
        out_ready = rdy;
        #1;
    endtask

    // Compare {grant,sel,busy,out_valid,beat} as one packed value.
    task automatic chk_st(input string name, input logic [2:0] g, input logic [1:0] s,
                          input logic b, input logic v, input logic bt);
        chk(name, {40'd0, grant, sel, busy, out_valid, beat}, {40'd0, g, s, b, v, bt});
    endtask

    initial begin
        rst_n = 1'b0; req = 3'b000; out_ready = 1'b1;

        // Round-robin with all three requesting.
        tbl[0]  = mk(1'b0, 3'b111, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 3'b111, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tbl[2 + k]  = mk(1'b1, 3'b111, 1'b1, 3'b001, 2'b00, 1'b1, 1'b1, 1'b1);
            tbl[6 + k]  = mk(1'b1, 3'b111, 1'b1, 3'b010, 2'b01, 1'b1, 1'b1, 1'b1);
            tbl[10 + k] = mk(1'b1, 3'b111, 1'b1, 3'b100, 2'b10, 1'b1, 1'b1, 1'b1);
        end
        tbl[14] = mk(1'b1, 3'b111, 1'b1, 3'b001, 2'b00, 1'b1, 1'b1, 1'b1);
        tbl[15] = mk(1'b1, 3'b000, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 3'b000, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);

        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b1);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst_n, tbl[i].req, tbl[i].rdy);
            chk_st($sformatf("rr_vec%0d", i), tbl[i].grant, tbl[i].sel,
                   tbl[i].busy, tbl[i].ov, tbl[i].bt);
        end

        // Single requester re-grants itself back-to-back: 9 beats in 10 cycles.
        beats = 0;
        drive(1'b1, 3'b010, 1'b1);
        chk_st("single_c0", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            drive(1'b1, 3'b010, 1'b1);
            chk_st($sformatf("single_c%0d", c), 3'b010, 2'b01, 1'b1, 1'b1, 1'b1);
            if (beat === 1'b1) beats++;
        end
        chk("single_beats", 48'(beats), 48'd9);
        drive(1'b1, 3'b000, 1'b1);
        chk_st("single_drop", 3'b010, 2'b01, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b1);
        chk_st("single_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Early release: owner 0 drops after 2 beats, req2 takes a full fresh burst.
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b1, 3'b101, 1'b1);
        chk_st("early_c0", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            drive(1'b1, 3'b101, 1'b1);
            chk_st($sformatf("early_c%0d", c), 3'b001, 2'b00, 1'b1, 1'b1, 1'b1);
        end
        drive(1'b1, 3'b100, 1'b1);
        chk_st("early_drop", 3'b001, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int c = 4; c <= 7; c++) begin
            drive(1'b1, 3'b101, 1'b1);
            chk_st($sformatf("early_c%0d", c), 3'b100, 2'b10, 1'b1, 1'b1, 1'b1);
        end
        drive(1'b1, 3'b000, 1'b1);
        chk_st("early_rotate", 3'b001, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b1);
        chk_st("early_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Stall for 5 cycles after 2 beats; remaining 2 beats then rotate.
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b1, 3'b011, 1'b1);
        chk_st("stall_c0", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            drive(1'b1, 3'b011, 1'b1);
            chk_st($sformatf("stall_c%0d", c), 3'b001, 2'b00, 1'b1, 1'b1, 1'b1);
        end
        for (int c = 3; c <= 7; c++) begin
            drive(1'b1, 3'b011, 1'b0);
            chk_st($sformatf("stall_hold%0d", c), 3'b001, 2'b00, 1'b1, 1'b1, 1'b0);
        end
        for (int c = 8; c <= 9; c++) begin
            drive(1'b1, 3'b011, 1'b1);
            chk_st($sformatf("stall_c%0d", c), 3'b001, 2'b00, 1'b1, 1'b1, 1'b1);
        end
        drive(1'b1, 3'b000, 1'b1);
        chk_st("stall_rotate", 3'b010, 2'b01, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b1);
        chk_st("stall_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset asserted on beat 3 drops the beat and restarts from requester 0.
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b1, 3'b011, 1'b1);
        chk_st("rstmid_c0", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            drive(1'b1, 3'b011, 1'b1);
            chk_st($sformatf("rstmid_c%0d", c), 3'b001, 2'b00, 1'b1, 1'b1, 1'b1);
        end
        drive(1'b0, 3'b011, 1'b1);
        chk_st("rstmid_low", 3'b001, 2'b00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 1'b1);
        chk_st("rstmid_after", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 1'b1);
        chk_st("rstmid_regrant", 3'b001, 2'b00, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 3'b000, 1'b1);
        drive(1'b1, 3'b000, 1'b1);

`ifdef ARB_STATS_EN
        // 16 back-to-back beats shared between requesters 0 and 2.
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b1, 3'b101, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            drive(1'b1, 3'b101, 1'b1);
        end
        drive(1'b1, 3'b000, 1'b1);
        chk("stats_fields", stat_beats, {16'd8, 16'd0, 16'd8});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
